// File: rtl/wb_stage.sv
// Writeback stage: final pipeline register between MEM and the register file.
// Drives the regfile write port, ID forwarding bus, exception flush, debug trace and retire counter.
module wb_stage #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ms_to_ws_valid,
  output logic              ws_allowin,
  input  logic [PC_W-1:0]   ms_pc,
  input  logic [3:0]        ms_gr_we,
  input  logic [4:0]        ms_dest,
  input  logic [DATA_W-1:0] ms_result,
  input  logic              ms_ex,
  input  logic              ws_stall,
  output logic [3:0]        rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              ws_fwd_valid,
  output logic [4:0]        ws_fwd_dest,
  output logic [DATA_W-1:0] ws_fwd_data,
  output logic              ws_ex_flush,
  output logic [PC_W-1:0]   ws_ex_pc,
  output logic [PC_W-1:0]   debug_wb_pc,
  output logic [3:0]        debug_wb_rf_we,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata,
  output logic [31:0]       retired_cnt
);

  logic              vld_p0;
  logic [PC_W-1:0]   pc_p0;
  logic [3:0]        gr_we_p0;
  logic [4:0]        dest_p0;
  logic [DATA_W-1:0] result_p0;
  logic              ex_p0;
  logic [31:0]       retired_cnt_p0;

  logic ws_ready_go;
  logic fire;
  logic retire;

  // Byte-lane enable actually committed; excepting or r0-targeted writes are dropped.
  function automatic logic [3:0] commit_we(input logic go, input logic ex,
                                           input logic [4:0] dest, input logic [3:0] we);
    commit_we = (go && !ex && (dest != 5'd0)) ? we : 4'b0000;
  endfunction

  assign ws_ready_go = !ws_stall;
  assign ws_allowin  = !vld_p0 || ws_ready_go;
  assign fire        = vld_p0 && ws_ready_go;
  assign retire      = fire && !ex_p0;

  // MEM -> WB register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0    <= 1'b0;
      pc_p0     <= '0;
      gr_we_p0  <= '0;
      dest_p0   <= '0;
      result_p0 <= '0;
      ex_p0     <= 1'b0;
    end else if (ws_allowin) begin
      vld_p0 <= ms_to_ws_valid;
      if (ms_to_ws_valid) begin
        pc_p0     <= ms_pc;
        gr_we_p0  <= ms_gr_we;
        dest_p0   <= ms_dest;
        result_p0 <= ms_result;
        ex_p0     <= ms_ex;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_cnt_p0 <= '0;
    end else if (retire) begin
      retired_cnt_p0 <= retired_cnt_p0 + 32'd1;
    end
  end

  // WB outputs (combinational from the WB register)
  assign rf_we    = commit_we(fire, ex_p0, dest_p0, gr_we_p0);
  assign rf_waddr = dest_p0;
  assign rf_wdata = result_p0;

  // Forwarding stays valid while stalled: the latched result is already final.
  assign ws_fwd_valid = vld_p0 && !ex_p0 && (|gr_we_p0) && (dest_p0 != 5'd0);
  assign ws_fwd_dest  = dest_p0;
  assign ws_fwd_data  = result_p0;

  assign ws_ex_flush = fire && ex_p0;
  assign ws_ex_pc    = pc_p0;

  assign debug_wb_pc       = pc_p0;
  assign debug_wb_rf_we    = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  assign retired_cnt = retired_cnt_p0;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// checked against a transaction-level model of the WB slot and retire counter.
module tb_wb_stage;

  localparam int PC_W   = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              ms_to_ws_valid;
  logic              ws_allowin;
  logic [PC_W-1:0]   ms_pc;
  logic [3:0]        ms_gr_we;
  logic [4:0]        ms_dest;
  logic [DATA_W-1:0] ms_result;
  logic              ms_ex;
  logic              ws_stall;
  logic [3:0]        rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              ws_fwd_valid;
  logic [4:0]        ws_fwd_dest;
  logic [DATA_W-1:0] ws_fwd_data;
  logic              ws_ex_flush;
  logic [PC_W-1:0]   ws_ex_pc;
  logic [PC_W-1:0]   debug_wb_pc;
  logic [3:0]        debug_wb_rf_we;
  logic [4:0]        debug_wb_rf_wnum;
  logic [DATA_W-1:0] debug_wb_rf_wdata;
  logic [31:0]       retired_cnt;

  wb_stage #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
    .ms_result(ms_result), .ms_ex(ms_ex), .ws_stall(ws_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_fwd_valid(ws_fwd_valid), .ws_fwd_dest(ws_fwd_dest), .ws_fwd_data(ws_fwd_data),
    .ws_ex_flush(ws_ex_flush), .ws_ex_pc(ws_ex_pc),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .retired_cnt(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: the instruction currently sitting in WB (if any) and the retire count.
  logic        m_v;
  logic [31:0] m_pc, m_res, m_cnt;
  logic [3:0]  m_we;
  logic [4:0]  m_dest;
  logic        m_ex;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_v = 0; m_pc = 0; m_res = 0; m_cnt = 0; m_we = 0; m_dest = 0; m_ex = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_allowin"}, ws_allowin, 1);
    check({tag, "_we"}, rf_we, 0);
    check({tag, "_waddr"}, rf_waddr, 0);
    check({tag, "_wdata"}, rf_wdata, 0);
    check({tag, "_fwdv"}, ws_fwd_valid, 0);
    check({tag, "_fwdd"}, {ws_fwd_dest, ws_fwd_data}, 0);
    check({tag, "_flush"}, ws_ex_flush, 0);
    check({tag, "_expc"}, ws_ex_pc, 0);
    check({tag, "_dbg"}, {debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata}, 0);
    check({tag, "_cnt"}, retired_cnt, 0);
  endtask

  // Called at negedge: drive one cycle of MEM inputs, compare every output to the
  // model, advance the model across the coming rising edge, return at next negedge.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [3:0] we,
                       input logic [4:0] dest, input logic [31:0] res,
                       input logic ex, input logic stall);
    logic        leaving, acc;
    logic [3:0]  e_we;
    ms_to_ws_valid = v; ms_pc = pc; ms_gr_we = we; ms_dest = dest;
    ms_result = res; ms_ex = ex; ws_stall = stall;
    #1;
    leaving = m_v && !stall;
    acc     = !m_v || !stall;
    e_we    = (leaving && !m_ex && m_dest != 0) ? m_we : 4'h0;
    check("allowin", ws_allowin, acc);
    check("rf_we", rf_we, e_we);
    check("rf_waddr", rf_waddr, m_dest);
    check("rf_wdata", rf_wdata, m_res);
    check("fwd_valid", ws_fwd_valid, m_v && !m_ex && m_we != 0 && m_dest != 0);
    check("fwd_bus", {ws_fwd_dest, ws_fwd_data}, {m_dest, m_res});
    check("flush", ws_ex_flush, leaving && m_ex);
    check("ex_pc", ws_ex_pc, m_pc);
    check("dbg", {debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata},
          {m_pc, e_we, m_dest, m_res});
    check("retired", retired_cnt, m_cnt);
    if (leaving && !m_ex) m_cnt = m_cnt + 1;
    if (acc) begin
      m_v = v;
      if (v) begin
        m_pc = pc; m_we = we; m_dest = dest; m_res = res; m_ex = ex;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(0, 32'h0, 4'h0, 5'd0, 32'h0, 0, 0);
  endtask

  logic [31:0] saved;
  logic [3:0]  we_tab [5];

  initial begin
    we_tab[0] = 4'h0; we_tab[1] = 4'hF; we_tab[2] = 4'h3; we_tab[3] = 4'h1; we_tab[4] = 4'hC;
    reset = 1; ms_to_ws_valid = 0; ms_pc = 0; ms_gr_we = 0; ms_dest = 0;
    ms_result = 0; ms_ex = 0; ws_stall = 0;
    model_clear();
    @(negedge clk); @(negedge clk);
    check_all_zero("rst");
    reset = 0;

    // Single write
    cycle(1, 32'h1C000000, 4'hF, 5'd5, 32'hDEADBEEF, 0, 0);
    check("sw_we", rf_we, 4'hF);
    check("sw_addr", rf_waddr, 5);
    check("sw_data", rf_wdata, 32'hDEADBEEF);
    check("sw_pc", debug_wb_pc, 32'h1C000000);
    idle();
    check("sw_cnt", retired_cnt, 1);

    // Stall three cycles, then exactly one commit
    cycle(1, 32'h1C000000, 4'hF, 5'd5, 32'hDEADBEEF, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 32'h0, 4'h0, 5'd0, 32'h0, 0, 1);
      check("st_we", rf_we, 0);
      check("st_allowin", ws_allowin, 0);
      check("st_fwdv", ws_fwd_valid, 1);
      check("st_fwdd", ws_fwd_data, 32'hDEADBEEF);
    end
    cycle(0, 32'h0, 4'h0, 5'd0, 32'h0, 0, 0);
    idle();
    check("st_cnt", retired_cnt, 2);

    // Exception
    saved = retired_cnt;
    cycle(1, 32'h1C000040, 4'hF, 5'd7, 32'h12345678, 1, 0);
    check("ex_flush", ws_ex_flush, 1);
    check("ex_we", rf_we, 0);
    check("ex_pc_c", ws_ex_pc, 32'h1C000040);
    idle();
    check("ex_flush_end", ws_ex_flush, 0);
    check("ex_cnt", retired_cnt, saved);

    // Exception held by stall, flushes once on release
    cycle(1, 32'h1C000080, 4'hF, 5'd9, 32'h55, 1, 0);
    cycle(0, 32'h0, 4'h0, 5'd0, 32'h0, 0, 1);
    check("exst_noflush", ws_ex_flush, 0);
    cycle(0, 32'h0, 4'h0, 5'd0, 32'h0, 0, 1);
    cycle(0, 32'h0, 4'h0, 5'd0, 32'h0, 0, 0);
    idle();

    // Zero destination, then partial write
    saved = retired_cnt;
    cycle(1, 32'h1C0000C0, 4'hF, 5'd0, 32'hAAAA5555, 0, 0);
    check("z_we", rf_we, 0);
    cycle(1, 32'h1C0000C4, 4'h3, 5'd3, 32'h0000BEEF, 0, 0);
    check("p_we", rf_we, 4'h3);
    check("p_addr", rf_waddr, 3);
    idle();
    check("zp_cnt", retired_cnt, saved + 2);

    // Async reset while a stalled instruction is held
    cycle(1, 32'h1C000100, 4'hF, 5'd11, 32'hCAFEF00D, 0, 0);
    cycle(0, 32'h0, 4'h0, 5'd0, 32'h0, 0, 1);
    #1 reset = 1;
    #1 check_all_zero("arst");
    reset = 0;
    model_clear();
    @(negedge clk);
    idle();
    check("arst_we", rf_we, 0);
    check("arst_flush", ws_ex_flush, 0);
    check("arst_cnt", retired_cnt, 0);

    // Throughput: eight back-to-back instructions
    for (int i = 1; i <= 8; i++) begin
      cycle(1, 32'h1C000200 + 4 * i, 4'hF, 5'(i), 32'h100 + i, 0, 0);
      check("tp_we", rf_we, 4'hF);
      check("tp_addr", rf_waddr, i);
    end
    idle();
    check("tp_cnt", retired_cnt, 8);

    // Counter wrap
    cycle(1, 32'h1C000300, 4'hF, 5'd9, 32'h99, 0, 0);
    force dut.retired_cnt_p0 = 32'hFFFFFFFF;
    #1 release dut.retired_cnt_p0;
    m_cnt = 32'hFFFFFFFF;
    idle();
    check("wrap_cnt", retired_cnt, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), $urandom, we_tab[$urandom_range(0, 4)],
            5'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 25));
    end
    for (int i = 0; i < 3; i++) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the five-stage pipeline; final pipeline register between MEM and the register file.
- Accepts one retiring instruction per cycle from MEM over a valid/allowin handshake.
- Drives the register file write port (we[3:0], waddr, wdata) and a same-cycle forwarding bus to ID.
- Suppresses writes for excepting instructions, raises the flush pulse, exports the debug trace and a retired-instruction counter.

Parameters:
- PC_W, 32, PC width
- DATA_W, 32, register data width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- ms_to_ws_valid  in  1  MEM holds a valid instruction
- ws_allowin  out  1  WB can accept this cycle
- ms_pc  in  PC_W  instruction PC
- ms_gr_we  in  4  byte-lane write enable (4'b0000 = no write)
- ms_dest  in  5  destination register
- ms_result  in  DATA_W  final result
- ms_ex  in  1  instruction carries an exception
- ws_stall  in  1  external hold (e.g. CSR/debug); WB keeps its instruction
- rf_we  out  4  register file byte write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  DATA_W  register file write data
- ws_fwd_valid  out  1  forwarding entry valid (write pending this cycle)
- ws_fwd_dest  out  5  forwarding destination
- ws_fwd_data  out  DATA_W  forwarding data
- ws_ex_flush  out  1  one-cycle flush request to upstream stages
- ws_ex_pc  out  PC_W  PC of excepting instruction
- debug_wb_pc  out  PC_W  trace PC
- debug_wb_rf_we  out  4  trace write enable
- debug_wb_rf_wnum  out  5  trace register number
- debug_wb_rf_wdata  out  DATA_W  trace write data
- retired_cnt  out  32  count of non-excepting retired instructions

Behaviour:
- Reset values (async, immediate): ws_valid=0, all latched fields 0, retired_cnt=0, and therefore every output except ws_allowin is 0. ws_allowin=1 during and after reset.
- ws_ready_go = !ws_stall.
- ws_allowin = !ws_valid || ws_ready_go (combinational).
- Each rising edge with ws_allowin=1:
  - ws_valid <= ms_to_ws_valid.
  - If ms_to_ws_valid, latch pc/gr_we/dest/result/ex.
- With ws_allowin=0, all state holds.
- fire = ws_valid && ws_ready_go. Each instruction fires exactly once, in the cycle it leaves WB.
- Commit write: rf_we = (fire && !ws_ex && ws_dest!=0) ? ws_gr_we : 4'b0. rf_waddr = ws_dest. rf_wdata = ws_result.
- Outputs are combinational from the WB register (latency 1 cycle from acceptance). The regfile commits on the same edge that WB advances.
- Forwarding: ws_fwd_valid = ws_valid && !ws_ex && |ws_gr_we && ws_dest!=0. It is asserted even while stalled, because the data is final. ws_fwd_dest and ws_fwd_data mirror the latched fields.
- Exception: ws_ex_flush = fire && ws_ex, a one-cycle pulse. ws_ex_pc = ws_pc. No register write occurs and retired_cnt does not increment.
- Stall with exception: the flush is held off until ws_stall drops, then pulses exactly once.
- debug_wb_* mirror rf_we/rf_waddr/rf_wdata. debug_wb_pc = ws_pc.
- retired_cnt increments by 1 on each fire && !ws_ex, including instructions with no register write. It wraps 0xFFFFFFFF to 0.
- dest=0 with nonzero gr_we: write suppressed, instruction still counts as retired.
- Back-to-back instructions: full throughput of 1 per cycle when ws_stall=0.
- Reset mid-stall: instruction is discarded, no write, no flush.

Test Plan:
- Single write: pc=0x1C000000, gr_we=4'hF, dest=5, result=0xDEADBEEF, valid one cycle → next cycle rf_we=4'hF, rf_waddr=5, rf_wdata=0xDEADBEEF, debug_wb_pc=0x1C000000, retired_cnt=1.
- Stall: same instruction, ws_stall=1 for 3 cycles → rf_we=0 and ws_allowin=0 for 3 cycles with ws_fwd_valid=1, ws_fwd_data=0xDEADBEEF. In the cycle stall drops, rf_we=4'hF exactly once.
- Exception: ms_ex=1, dest=7, gr_we=4'hF → rf_we=0, ws_ex_flush=1 for one cycle, ws_ex_pc=pc, retired_cnt unchanged.
- Zero destination and partial write: dest=0, gr_we=4'hF → rf_we=0, retired_cnt+1. Then dest=3, gr_we=4'h3 → rf_we=4'h3.
- Throughput: 8 consecutive valid instructions, dest=1..8 → 8 consecutive write cycles in order, retired_cnt=8. Counter preloaded by forcing 0xFFFFFFFF then one retire → 0.
- Async reset: assert reset mid-cycle while a stalled valid instruction is held → all outputs 0 before the next edge. After release, no write or flush occurs for the discarded instruction.
